tone_decoder: RTL

Receive-side counterpart of the piano tone generator. Takes the square-wave speaker line and measures its period in clk cycles. Classifies each period against three note periods, one per button, and reports which button is being played.
Used as a loopback checker and as the front end of an audio-to-key recognizer. Output btn_n mirrors the generator's active-low btn encoding, so btn_n == btn whenever the decoder is locked.

---
 rtl/tone_decoder.sv | 93 +++++++++
 1 files changed

// File: rtl/tone_decoder.sv
// tone_decoder: measures the speaker square-wave period and locks onto one of three note periods
module tone_decoder #(
    parameter int PERIOD0    = 190840,
    parameter int PERIOD1    = 151515,
    parameter int PERIOD2    = 127551,
    parameter int TOL_SHIFT  = 5,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 400000,
    parameter int CNT_W      = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             speaker,
    output logic             note_valid,
    output logic [1:0]       note_id,
    output logic [2:0]       btn_n,
    output logic [CNT_W-1:0] period_out,
    output logic             period_strobe
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W:0]   P0 = (CNT_W+1)'(PERIOD0);
    localparam logic [CNT_W:0]   P1 = (CNT_W+1)'(PERIOD1);
    localparam logic [CNT_W:0]   P2 = (CNT_W+1)'(PERIOD2);
    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
    localparam logic [MW-1:0]    LC = MW'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    state_t           state;
    logic             s1, s2, s3, rise, v_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       cand, cls;
    logic [MW-1:0]    mcount, m_nxt;

    function automatic logic in_band(input logic [CNT_W:0] c, input logic [CNT_W:0] p);
        logic [CNT_W:0] d;
        d = c >= p ? c - p : p - c;
        return d <= (p >> TOL_SHIFT);
    endfunction

    // candidate always follows the latest class, so only mcount needs the match decision
    always_comb begin
        rise  = s2 & ~s3;
        cls   = in_band({1'b0, cnt}, P0) ? 2'd0 :
                in_band({1'b0, cnt}, P1) ? 2'd1 :
                in_band({1'b0, cnt}, P2) ? 2'd2 : 2'd3;
        m_nxt = (cls == cand && cls != 2'd3) ? (mcount == LC ? LC : mcount + MW'(1)) :
                (cls == 2'd3 ? '0 : MW'(1));
        v_nxt = m_nxt == LC;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {s1, s2, s3}  <= 3'b000;
            cnt           <= '0;
            state         <= IDLE;
            cand          <= 2'd3;
            mcount        <= '0;
            note_valid    <= 1'b0;
            note_id       <= 2'd3;
            btn_n         <= 3'b111;
            period_out    <= '0;
            period_strobe <= 1'b0;
        end else begin
            s1            <= speaker;
            s2            <= s1;
            s3            <= s2;
            period_strobe <= 1'b0;
            cnt           <= rise ? CNT_W'(1) : (&cnt ? cnt : cnt + CNT_W'(1));
            if (rise) begin
                if (state == IDLE) begin
                    state <= MEASURE;
                end else begin
                    period_out    <= cnt;
                    period_strobe <= 1'b1;
                    cand          <= cls;
                    mcount        <= m_nxt;
                    note_valid    <= v_nxt;
                    note_id       <= v_nxt ? cls : 2'd3;
                    btn_n         <= v_nxt ? ~(3'b001 << cls) : 3'b111;
                    state         <= v_nxt ? LOCKED : MEASURE;
                end
            end else if (state != IDLE && cnt == TO) begin
                state      <= IDLE;
                cand       <= 2'd3;
                mcount     <= '0;
                note_valid <= 1'b0;
                note_id    <= 2'd3;
                btn_n      <= 3'b111;
            end
        end
    end
endmodule
